// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect sequencer: turns a taken branch into a registered
// PC load plus a fixed IF/ID and ID/EX flush sequence, with target checks and stats.
module branch_redirect_ctrl #(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ex_valid,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             stall,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_next,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             busy,
   output logic             misalign_err,
   output logic             range_err,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REDIR = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_pc_load;
   logic             r_flush_ifid;
   logic             r_flush_idex;
   logic             r_busy;
   logic             r_mis;
   logic             r_rng;
   logic [PC_W-1:0]  r_pc;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_tk_cnt;

   logic             w_accept;
   logic             w_taken;
   logic             w_mis;
   logic             w_rng;
   logic [PC_W-1:0]  w_target;

   assign w_accept = (r_state == S_IDLE) && ex_valid && !stall;
   assign w_taken  = w_accept && PcSel;
   assign w_mis    = |BrPC[1:0];
   assign w_rng    = |BrPC[31:PC_W];
   assign w_target = {BrPC[PC_W-1:2], 2'b00};

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_taken) w_next = S_REDIR;
         S_REDIR: if (!stall)  w_next = S_FLUSH;
         S_FLUSH: if (!stall)  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_pc_load    <= 1'b0;
         r_flush_ifid <= 1'b0;
         r_flush_idex <= 1'b0;
         r_busy       <= 1'b0;
         r_mis        <= 1'b0;
         r_rng        <= 1'b0;
         r_pc         <= '0;
         r_br_cnt     <= '0;
         r_tk_cnt     <= '0;
      end else begin
         r_state      <= w_next;
         r_pc_load    <= (w_next == S_REDIR);
         r_flush_idex <= (w_next == S_REDIR);
         r_flush_ifid <= (w_next != S_IDLE);
         r_busy       <= (w_next != S_IDLE);
         if (w_accept && r_br_cnt != CNT_MAX)
            r_br_cnt <= r_br_cnt + CNT_ONE;
         if (w_taken) begin
            r_pc <= w_target;
            if (r_tk_cnt != CNT_MAX) r_tk_cnt <= r_tk_cnt + CNT_ONE;
            if (w_mis) r_mis <= 1'b1;
            if (w_rng) r_rng <= 1'b1;
         end
      end
   end

   assign pc_load      = r_pc_load;
   assign pc_next      = r_pc;
   assign flush_ifid   = r_flush_ifid;
   assign flush_idex   = r_flush_idex;
   assign busy         = r_busy;
   assign misalign_err = r_mis;
   assign range_err    = r_rng;
   assign br_count     = r_br_cnt;
   assign taken_count  = r_tk_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed plan steps plus random traffic
// checked against a schedule-queue reference model.
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        reset_n;
   logic        ex_valid;
   logic        PcSel;
   logic [31:0] BrPC;
   logic        stall;
   logic        pc_load;
   logic [8:0]  pc_next;
   logic        flush_ifid;
   logic        flush_idex;
   logic        busy;
   logic        misalign_err;
   logic        range_err;
   logic [15:0] br_count;
   logic [15:0] taken_count;

   int ncmp = 0;
   int nfail = 0;

   // reference model: queue of pending output slots (1 = redirect, 2 = flush)
   int          sched[$];
   int          mbr;
   int          mtk;
   int          mpc;
   bit          mmis;
   bit          mrng;
   int          base;

   branch_redirect_ctrl #(.PC_W(9), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .PcSel(PcSel),
      .BrPC(BrPC), .stall(stall), .pc_load(pc_load), .pc_next(pc_next),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .busy(busy),
      .misalign_err(misalign_err), .range_err(range_err),
      .br_count(br_count), .taken_count(taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      mbr = 0; mtk = 0; mpc = 0; mmis = 0; mrng = 0;
   endtask

   task automatic model_edge();
      if (sched.size() != 0) begin
         if (!stall) void'(sched.pop_front());
      end else if (ex_valid && !stall) begin
         if (mbr < 65535) mbr = mbr + 1;
         if (PcSel) begin
            if (mtk < 65535) mtk = mtk + 1;
            mpc = int'(BrPC % 512) - int'(BrPC % 4);
            if (BrPC % 4 != 0) mmis = 1;
            if (BrPC / 512 != 0) mrng = 1;
            sched.push_back(1);
            sched.push_back(2);
         end
      end
   endtask

   task automatic check_all();
      bit redir;
      redir = (sched.size() != 0) && (sched[0] == 1);
      chk("pc_load", {31'b0, pc_load}, {31'b0, redir});
      chk("flush_idex", {31'b0, flush_idex}, {31'b0, redir});
      chk("flush_ifid", {31'b0, flush_ifid}, {31'b0, sched.size() != 0});
      chk("busy", {31'b0, busy}, {31'b0, sched.size() != 0});
      chk("pc_next", {23'b0, pc_next}, mpc);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, mmis});
      chk("range_err", {31'b0, range_err}, {31'b0, mrng});
      chk("br_count", {16'b0, br_count}, mbr);
      chk("taken_count", {16'b0, taken_count}, mtk);
   endtask

   task automatic step(input logic ev, input logic ps, input logic [31:0] br,
                       input logic st, input bit do_chk);
      ex_valid = ev; PcSel = ps; BrPC = br; stall = st;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (do_chk) check_all();
   endtask

   initial begin
      reset_n = 1'b0; ex_valid = 0; PcSel = 0; BrPC = '0; stall = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      reset_n = 1'b1;

      // four not-taken accepts
      for (int i = 0; i < 4; i++) step(1, 0, 32'h100, 0, 1);
      chk("nt_br_count", {16'b0, br_count}, 32'd4);

      // clean taken branch: N+1 redirect, N+2 flush, N+3 idle
      step(1, 1, 32'h40, 0, 1);
      chk("tk_pc_next", {23'b0, pc_next}, 32'h40);
      chk("tk_pc_load", {31'b0, pc_load}, 32'd1);
      step(1, 1, 32'h80, 0, 1);
      chk("tk_flush_only", {29'b0, pc_load, flush_ifid, flush_idex}, 32'b010);
      step(0, 0, 32'h0, 0, 1);
      chk("tk_idle_busy", {31'b0, busy}, 32'd0);
      chk("tk_taken_count", {16'b0, taken_count}, 32'd1);

      // stall held for 3 cycles in REDIRECT
      step(1, 1, 32'h88, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 1, 32'h0, 1, 1);
      chk("stall_redir_held", {31'b0, pc_load}, 32'd1);
      step(0, 0, 32'h0, 0, 1);
      chk("stall_flush", {29'b0, pc_load, flush_ifid, flush_idex}, 32'b010);
      step(0, 0, 32'h0, 0, 1);

      // taken branch held by stall in IDLE counts once
      base = mbr;
      step(1, 1, 32'h20, 1, 1);
      step(1, 1, 32'h20, 1, 1);
      step(1, 1, 32'h20, 0, 1);
      chk("stall_idle_once", {16'b0, br_count}, base + 1);
      step(0, 0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 0, 1);

      // bad target: cleaned redirect, sticky flags
      step(1, 1, 32'h0000_0A06, 0, 1);
      chk("bad_pc_next", {23'b0, pc_next}, 32'h004);
      for (int i = 0; i < 11; i++) step(0, 0, 32'h0, 0, 1);
      chk("sticky_flags", {30'b0, misalign_err, range_err}, 32'b11);
      step(1, 1, 32'h10, 0, 1);
      chk("clean_pc_next", {23'b0, pc_next}, 32'h010);
      chk("clean_flags", {30'b0, misalign_err, range_err}, 32'b11);
      step(0, 0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom;
         if ($urandom_range(0, 2) != 0) r = r & 32'h1FC;
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), r,
              ($urandom_range(0, 3) == 0), 1);
      end

      // run the branch counter into saturation
      for (int i = 0; i < 65600; i++) step(1, 0, 32'h0, 0, 0);
      check_all();
      chk("br_saturated", {16'b0, br_count}, 32'hFFFF);
      step(1, 0, 32'h0, 0, 1);
      chk("br_no_wrap", {16'b0, br_count}, 32'hFFFF);

      // async reset in the middle of a redirect
      step(1, 1, 32'h44, 0, 1);
      chk("pre_rst_load", {31'b0, pc_load}, 32'd1);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async_outs", {28'b0, pc_load, flush_ifid, flush_idex, busy},
          32'b0);
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 32'h0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller for the EX-stage branch unit. It samples the branch unit's taken decision and target each cycle and converts a taken branch or jump into a registered PC redirect plus a fixed pipeline flush sequence, honouring memory stalls. It also flags bad targets and keeps branch statistics. It sits between the branch unit outputs (PcSel, BrPC) and the PC register / IF-ID / ID-EX pipeline registers.

## Interface

Parameters:
- PC_W, 9, width of the PC register; targets are truncated to this width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- ex_valid  input  1  EX stage holds a real branch/jump (not a bubble).
- PcSel  input  1  branch unit taken decision (1 = taken).
- BrPC  input  32  branch unit target address.
- stall  input  1  pipeline freeze from memory; the EX contents are held while high.
- pc_load  output  1  load pc_next into the PC register.
- pc_next  output  PC_W  redirect target.
- flush_ifid  output  1  clear the IF/ID register to a bubble.
- flush_idex  output  1  clear the ID/EX register to a bubble.
- busy  output  1  high in any state other than IDLE.
- misalign_err  output  1  sticky; an accepted target had BrPC[1:0] != 0.
- range_err  output  1  sticky; an accepted target had BrPC[31:PC_W] != 0.
- br_count  output  CNT_W  accepted branch/jump count, saturating.
- taken_count  output  CNT_W  taken count, saturating.

## Operation

- FSM states: IDLE, REDIRECT, FLUSH.
- Accept condition: state == IDLE && ex_valid && !stall.
- IDLE:
  - On accept, br_count increments.
  - If PcSel is also 1: capture target = {BrPC[PC_W-1:2], 2'b00} into pc_next, increment taken_count, and go to REDIRECT.
  - If PcSel is 0, stay in IDLE.
- REDIRECT: pc_load=1, flush_ifid=1, flush_idex=1.
  - If !stall, go to FLUSH.
  - If stall, hold the state with all outputs unchanged.
- FLUSH: flush_ifid=1, pc_load=0, flush_idex=0.
  - If !stall, go to IDLE.
  - If stall, hold.
- ex_valid and PcSel are ignored in REDIRECT and FLUSH, because EX contains wrong-path work or a bubble then.
- In IDLE all of pc_load, flush_ifid and flush_idex are 0. pc_next holds its last captured value.
- Target checks, on a taken accept only:
  - BrPC[1:0] != 0 sets misalign_err.
  - Any bit of BrPC[31:PC_W] set sets range_err.
  - Both flags are sticky until reset.
  - The redirect proceeds anyway, using the cleaned target.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset, asynchronous and immediate, from any state:
  - State returns to IDLE.
  - pc_load, flush_ifid, flush_idex, busy, misalign_err, range_err, pc_next, br_count and taken_count all go to 0.
  - A redirect in progress is abandoned.

## Timing

- A taken accept at the rising edge of cycle N produces:
  - Cycle N+1: pc_load=1 with pc_next valid, flush_ifid=1, flush_idex=1.
  - Cycle N+2: flush_ifid=1.
  - Cycle N+3: IDLE; the earliest next accept is at the edge ending N+3.
- A not-taken accept has no redirect and no flush; back-to-back accepts are possible every cycle.
- Stall in IDLE blocks the accept. The held branch is accepted exactly once, on the first edge with stall=0, so it is counted once.
- Stall in REDIRECT or FLUSH extends that state cycle-for-cycle.
- busy is registered and equals (state != IDLE).
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Test plan

- Reset, then hold ex_valid=1, PcSel=0 for 4 cycles -> no pc_load or flush; br_count=4, taken_count=0, busy=0.
- Taken accept with BrPC=0x0000_0040 at edge N -> N+1: pc_load=1, pc_next=0x040, flush_ifid=1, flush_idex=1; N+2: flush_ifid=1 only; N+3: IDLE; taken_count=1.
- Taken branch, then stall=1 for 3 cycles starting in REDIRECT -> pc_load, flush_ifid and flush_idex stay 1 for 4 cycles total, then FLUSH for 1 cycle. A taken branch presented with stall=1 in IDLE is accepted once when stall drops: br_count increments by 1.
- Taken accept with BrPC=0x0000_0A06 (PC_W=9) -> pc_next=0x004, misalign_err=1 and range_err=1, both still 1 after 10 idle cycles. A following clean BrPC=0x10 redirects to 0x010 with the flags still 1.
- Force br_count to 0xFFFE (or run 65537 accepts) -> count stops at 0xFFFF. Assert reset_n=0 mid-REDIRECT -> pc_load and flush outputs drop asynchronously, before the next clock edge; all counters and flags read 0.
